controller_uart1_tx_engine: RTL

Downstream consumer of the 2-bit UART1 write-control PIO. It takes ctrl[1:0] from that PIO: bit0 = tx_enable, bit1 = fifo_flush. It also exposes a small Avalon-MM slave for queuing bytes. Queued bytes pass through an internal FIFO and are serialised as 8N1 frames on txd at a fixed baud divisor.

---
 rtl/controller_uart1_tx_engine.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/controller_uart1_tx_engine.sv
// UART1 transmit engine: Avalon-MM byte queue feeding an 8N1 serialiser, gated by the ctrl PIO.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit between data and stop.
module controller_uart1_tx_engine #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4,
  parameter int BAUD_DIV   = 434
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [1:0]  ctrl,
  output logic        txd,
  output logic        tx_busy
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  state_t             state_q, state_d;
  logic [BW-1:0]      baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;

  logic wr, push, ovf_clr, flush, tx_en, empty, full, pop, push_ok, ovf_set, baud_end;
  logic unused_wd;

  assign unused_wd = ^writedata[31:8];
  assign wr        = chipselect & ~write_n;
  assign push      = wr & (address == 3'd0);
  assign ovf_clr   = wr & (address == 3'd1);
  assign tx_en     = ctrl[0];
  assign flush     = ctrl[1];
  assign empty     = (count_q == '0);
  assign full      = (count_q == (FIFO_AW+1)'(FIFO_DEPTH));
  // Flush wins over both a pop and a push in the same cycle.
  assign pop       = (state_q == S_IDLE) & tx_en & ~empty & ~flush;
  assign push_ok   = push & ~flush & (~full | pop);
  assign ovf_set   = push & ~flush & full & ~pop;
  assign baud_end  = (baud_q == BW'(BAUD_DIV - 1));
  assign tx_busy   = (state_q != S_IDLE);

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_FLAG = 1'b1;
  logic par_q, par_d;
`else
  localparam logic PAR_FLAG = 1'b0;
`endif

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop);
    end
    if (ovf_clr)      ovf_d = 1'b0;
    else if (ovf_set) ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd     = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != S_IDLE) baud_d = baud_end ? '0 : baud_q + BW'(1);
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          bit_d   = '0;
          baud_d  = '0;
          state_d = S_START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^mem_q[rd_ptr_q];
`endif
        end
      end
      S_START: begin
        txd = 1'b0;
        if (baud_end) state_d = S_DATA;
      end
      S_DATA: begin
        txd = shift_q[0];
        if (baud_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        txd = par_q;
        if (baud_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        txd = 1'b1;
        if (baud_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= writedata[7:0];
  end

  always_comb begin
    case (address)
      3'd1:    readdata = {26'b0, PAR_FLAG, tx_en, ovf_q, tx_busy, full, empty};
      3'd2:    readdata = {{(31-FIFO_AW){1'b0}}, count_q};
      default: readdata = 32'b0;
    endcase
  end

endmodule
